instr_fetch_unit: RTL and testbench

- Fetch stage of the lab MIPS control path.
- Holds the program counter, runs a request/acknowledge handshake with instruction memory, and latches each fetched word into an instruction register.
- Presents the word to the decode stage (main decoder / ALU decoder) through a valid/ready handshake, with Opcode and Funct pre-split.
- Accepts branch redirects from the execute stage.

---
 rtl/instr_fetch_unit_if.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, decode valid/ready
// with pre-split fields, execute-stage branch redirect and the fetch counter.
// master : fetch unit side (drives Imem_Req/Addr, Instr*, PC_*, Fetch_Count)
// slave  : environment side (memory, decode and execute stages)
interface instr_fetch_unit_if;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned FLD_W = 6;
  localparam int unsigned CNT_W = 16;

  // Instruction memory handshake
  logic             Imem_Req;
  logic [XLEN-1:0]  Imem_Addr;
  logic             Imem_Ack;
  logic [XLEN-1:0]  Imem_Data;

  // Decode-stage handshake and payload
  logic             Instr_Valid;
  logic             Instr_Ready;
  logic [XLEN-1:0]  Instr;
  logic [FLD_W-1:0] Opcode;
  logic [FLD_W-1:0] Funct;
  logic [XLEN-1:0]  PC_Out;
  logic [XLEN-1:0]  PC_Plus4;

  // Execute-stage redirect
  logic             Branch_Taken;
  logic [XLEN-1:0]  Branch_Target;

  // Accepted-instruction counter
  logic [CNT_W-1:0] Fetch_Count;

  modport master (
    output Imem_Req, Imem_Addr,
    input  Imem_Ack, Imem_Data,
    output Instr_Valid,
    input  Instr_Ready,
    output Instr, Opcode, Funct, PC_Out, PC_Plus4,
    input  Branch_Taken, Branch_Target,
    output Fetch_Count
  );

  modport slave (
    input  Imem_Req, Imem_Addr,
    output Imem_Ack, Imem_Data,
    input  Instr_Valid,
    output Instr_Ready,
    input  Instr, Opcode, Funct, PC_Out, PC_Plus4,
    output Branch_Taken, Branch_Target,
    input  Fetch_Count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the lab MIPS control path. Holds the PC, runs a req/ack
// handshake with instruction memory, latches the fetched word into an
// instruction register and offers it to decode via valid/ready. Branch
// redirects from execute either retarget the PC directly or, while a memory
// request is outstanding, are parked until the ack so the old word is dropped.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   fetch_if : instr_fetch_unit_if.master (memory, decode, redirect, counter)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_unit_if.master     fetch_if
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              redirect_pend_q, redirect_pend_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   target_c;

  // Redirect address with the byte-offset bits forced to zero
  assign target_c = fetch_if.Branch_Target & ~XLEN'(3);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack that must be discarded passes through IDLE so
  // memory sees Imem_Req drop before the redirected request
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (fetch_if.Imem_Ack) begin
          if (redirect_pend_q || fetch_if.Branch_Taken) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (fetch_if.Instr_Ready || fetch_if.Branch_Taken) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    pc_d            = pc_q;
    redirect_pc_d   = redirect_pc_q;
    redirect_pend_d = redirect_pend_q;
    instr_d         = instr_q;
    pc_out_d        = pc_out_q;
    fetch_cnt_d     = fetch_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_if.Branch_Taken) begin
          pc_d = target_c;
        end
      end
      S_REQ: begin
        if (fetch_if.Imem_Ack) begin
          redirect_pend_d = 1'b0;
          if (fetch_if.Branch_Taken) begin
            // Same-cycle branch is the newest redirect and wins
            pc_d = target_c;
          end else if (redirect_pend_q) begin
            pc_d = redirect_pc_q;
          end else begin
            instr_d  = fetch_if.Imem_Data;
            pc_out_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
          end
        end else if (fetch_if.Branch_Taken) begin
          // PC must stay stable under the outstanding request; park the target
          redirect_pc_d   = target_c;
          redirect_pend_d = 1'b1;
        end
      end
      S_FULL: begin
        if (fetch_if.Instr_Ready) begin
          fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
        if (fetch_if.Branch_Taken) begin
          pc_d = target_c;
        end
      end
      default: ;
    endcase
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_FULL);
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC & ~XLEN'(3);
      redirect_pc_q   <= '0;
      redirect_pend_q <= 1'b0;
      instr_q         <= '0;
      pc_out_q        <= '0;
      fetch_cnt_q     <= '0;
      req_q           <= 1'b0;
      valid_q         <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      redirect_pc_q   <= redirect_pc_d;
      redirect_pend_q <= redirect_pend_d;
      instr_q         <= instr_d;
      pc_out_q        <= pc_out_d;
      fetch_cnt_q     <= fetch_cnt_d;
      req_q           <= req_d;
      valid_q         <= valid_d;
    end
  end

  assign fetch_if.Imem_Req    = req_q;
  assign fetch_if.Imem_Addr   = pc_q;
  assign fetch_if.Instr_Valid = valid_q;
  assign fetch_if.Instr       = instr_q;
  assign fetch_if.Opcode      = instr_q[31:26];
  assign fetch_if.Funct       = instr_q[5:0];
  assign fetch_if.PC_Out      = pc_out_q;
  assign fetch_if.PC_Plus4    = pc_out_q + XLEN'(4);
  assign fetch_if.Fetch_Count = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a zero-based instance carries the main checks,
// a second instance with RESET_PC = 32'hFFFF_FFFC follows the same stimulus
// to exercise PC wrap-around and reset during a request.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] word;
    int          wait_n;
    logic [5:0]  exp_op;
    logic [5:0]  exp_funct;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [31:0] model_pc;
  exp_t exp_q[$];

  instr_fetch_unit_if if0();
  instr_fetch_unit_if if1();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut0 (
    .clk(clk), .reset(reset), .fetch_if(if0.master)
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk(clk), .reset(reset), .fetch_if(if1.master)
  );

  // Second instance mirrors the stimulus of the first
  assign if1.Imem_Ack      = if0.Imem_Ack;
  assign if1.Imem_Data     = if0.Imem_Data;
  assign if1.Instr_Ready   = if0.Instr_Ready;
  assign if1.Branch_Taken  = if0.Branch_Taken;
  assign if1.Branch_Target = if0.Branch_Target;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: every instruction accepted by decode must match the oldest expectation
  always @(posedge clk) begin
    if (!reset && if0.Instr_Valid && if0.Instr_Ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected_accept: got instr %h pc %h, want none", if0.Instr, if0.PC_Out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr", if0.Instr, e.word);
        check("sb_pc", if0.PC_Out, e.pc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if0.Imem_Ack = 1'b0;
    if0.Imem_Data = '0;
    if0.Instr_Ready = 1'b0;
    if0.Branch_Taken = 1'b0;
    if0.Branch_Target = '0;
    repeat (2) step();
    exp_q.delete();
    model_pc = 32'h0;
    reset = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!if0.Imem_Req && n < 20) begin
      step();
      n++;
    end
    check("req_seen", 32'(if0.Imem_Req), 32'd1);
  endtask

  // Answer one memory request with `word` after `wait_n` wait cycles
  task automatic serve(input logic [31:0] word, input int wait_n, output int req_cyc);
    wait_req();
    req_cyc = cyc;
    check("imem_addr", if0.Imem_Addr, model_pc);
    exp_q.push_back('{pc: model_pc, word: word});
    for (int i = 0; i < wait_n; i++) begin
      step();
      check("req_hold", 32'(if0.Imem_Req), 32'd1);
    end
    if0.Imem_Ack = 1'b1;
    if0.Imem_Data = word;
    step();
    if0.Imem_Ack = 1'b0;
    if0.Imem_Data = '0;
    model_pc = model_pc + 32'd4;
    check("valid_after_ack", 32'(if0.Instr_Valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   c0, dummy;
    logic [31:0] held_instr;

    vecs[0] = '{32'h0022_1820, 0, 6'b000000, 6'b100000, 32'h0};
    vecs[1] = '{32'h8C01_0004, 0, 6'b100011, 6'b000100, 32'h4};
    vecs[2] = '{32'hAC01_0008, 0, 6'b101011, 6'b001000, 32'h8};
    vecs[3] = '{32'h1022_0003, 0, 6'b000100, 6'b000011, 32'hC};

    // Reset values and first lw fetch
    do_reset();
    check("rst_req", 32'(if0.Imem_Req), 32'd0);
    check("rst_valid", 32'(if0.Instr_Valid), 32'd0);
    check("rst_instr", if0.Instr, 32'h0);
    check("rst_pc_out", if0.PC_Out, 32'h0);
    check("rst_count", 32'(if0.Fetch_Count), 32'd0);
    check("rst_addr", if0.Imem_Addr, 32'h0);
    step();
    check("t1_req_rise", 32'(if0.Imem_Req), 32'd1);
    check("t1_addr", if0.Imem_Addr, 32'h0);
    exp_q.push_back('{pc: 32'h0, word: 32'h8C01_0004});
    if0.Imem_Ack = 1'b1;
    if0.Imem_Data = 32'h8C01_0004;
    step();
    if0.Imem_Ack = 1'b0;
    check("t1_valid", 32'(if0.Instr_Valid), 32'd1);
    check("t1_opcode", 32'(if0.Opcode), 32'(6'b100011));
    check("t1_pc_out", if0.PC_Out, 32'h0);
    check("t1_pc_plus4", if0.PC_Plus4, 32'h4);
    if0.Instr_Ready = 1'b1;
    step();
    if0.Instr_Ready = 1'b0;
    check("t1_count", 32'(if0.Fetch_Count), 32'd1);

    // Four-word stream with Ready held high
    do_reset();
    if0.Instr_Ready = 1'b1;
    c0 = 0;
    for (int i = 0; i < 4; i++) begin
      int rc;
      serve(vecs[i].word, vecs[i].wait_n, rc);
      if (i == 0) c0 = rc;
      check("t2_opcode", 32'(if0.Opcode), 32'(vecs[i].exp_op));
      check("t2_funct", 32'(if0.Funct), 32'(vecs[i].exp_funct));
      check("t2_pc_out", if0.PC_Out, vecs[i].exp_pc);
    end
    step();
    if0.Instr_Ready = 1'b0;
    check("t2_count", 32'(if0.Fetch_Count), 32'd4);
    check("t2_throughput_cycles", 32'(cyc - c0), 32'd8);
    check("t2_next_addr", if0.Imem_Addr, 32'h10);

    // Decode stall: everything holds while Ready is low
    do_reset();
    serve(32'h2002_0005, 1, dummy);
    held_instr = 32'h2002_0005;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_instr_hold", if0.Instr, held_instr);
      check("t3_opcode_hold", 32'(if0.Opcode), 32'(6'b001000));
      check("t3_pc_hold", if0.PC_Out, 32'h0);
      check("t3_req_low", 32'(if0.Imem_Req), 32'd0);
      check("t3_count_hold", 32'(if0.Fetch_Count), 32'd0);
    end
    if0.Instr_Ready = 1'b1;
    step();
    if0.Instr_Ready = 1'b0;
    check("t3_count_inc", 32'(if0.Fetch_Count), 32'd1);
    check("t3_valid_fall", 32'(if0.Instr_Valid), 32'd0);
    serve(32'h0022_1820, 0, dummy);
    check("t3_next_pc_out", if0.PC_Out, 32'h4);

    // Branch while REQ waits three cycles for ack: acked word dropped
    do_reset();
    wait_req();
    if0.Branch_Taken = 1'b1;
    if0.Branch_Target = 32'h0000_0043;
    step();
    if0.Branch_Taken = 1'b0;
    check("t4_pc_held", if0.Imem_Addr, 32'h0);
    check("t4_req_held", 32'(if0.Imem_Req), 32'd1);
    step();
    step();
    if0.Imem_Ack = 1'b1;
    if0.Imem_Data = 32'hDEAD_BEEF;
    step();
    if0.Imem_Ack = 1'b0;
    check("t4_drop_valid", 32'(if0.Instr_Valid), 32'd0);
    check("t4_req_gap", 32'(if0.Imem_Req), 32'd0);
    check("t4_redirect_addr", if0.Imem_Addr, 32'h40);
    step();
    check("t4_valid_still_low", 32'(if0.Instr_Valid), 32'd0);
    model_pc = 32'h40;
    serve(32'h0022_1820, 0, dummy);
    check("t4_pc_out", if0.PC_Out, 32'h40);

    // Branch and Ready in the same FULL cycle
    do_reset();
    serve(32'hAC01_0008, 0, dummy);
    if0.Branch_Taken = 1'b1;
    if0.Branch_Target = 32'h0000_0100;
    if0.Instr_Ready = 1'b1;
    step();
    if0.Branch_Taken = 1'b0;
    if0.Instr_Ready = 1'b0;
    check("t5_count", 32'(if0.Fetch_Count), 32'd1);
    check("t5_valid_fall", 32'(if0.Instr_Valid), 32'd0);
    check("t5_req", 32'(if0.Imem_Req), 32'd1);
    check("t5_addr", if0.Imem_Addr, 32'h100);

    // Branch alone in FULL: word not consumed
    model_pc = 32'h100;
    serve(32'h1022_0003, 0, dummy);
    void'(exp_q.pop_back());
    if0.Branch_Taken = 1'b1;
    if0.Branch_Target = 32'h0000_0204;
    step();
    if0.Branch_Taken = 1'b0;
    check("t5b_count", 32'(if0.Fetch_Count), 32'd1);
    check("t5b_valid_fall", 32'(if0.Instr_Valid), 32'd0);
    check("t5b_addr", if0.Imem_Addr, 32'h204);

    // Ack and Branch in the same REQ cycle
    if0.Imem_Ack = 1'b1;
    if0.Imem_Data = 32'hFFFF_FFFF;
    if0.Branch_Taken = 1'b1;
    if0.Branch_Target = 32'h0000_0303;
    step();
    if0.Imem_Ack = 1'b0;
    if0.Branch_Taken = 1'b0;
    check("t5c_valid", 32'(if0.Instr_Valid), 32'd0);
    check("t5c_req_gap", 32'(if0.Imem_Req), 32'd0);
    check("t5c_addr", if0.Imem_Addr, 32'h300);
    step();
    check("t5c_req", 32'(if0.Imem_Req), 32'd1);

    // PC wrap on the high-reset instance, then reset during REQ
    do_reset();
    check("t6_rst_addr", if1.Imem_Addr, 32'hFFFF_FFFC);
    serve(32'h8C01_0004, 0, dummy);
    check("t6_valid", 32'(if1.Instr_Valid), 32'd1);
    check("t6_pc_out", if1.PC_Out, 32'hFFFF_FFFC);
    check("t6_pc_plus4", if1.PC_Plus4, 32'h0);
    if0.Instr_Ready = 1'b1;
    step();
    if0.Instr_Ready = 1'b0;
    check("t6_req", 32'(if1.Imem_Req), 32'd1);
    check("t6_wrap_addr", if1.Imem_Addr, 32'h0);
    check("t6_count", 32'(if1.Fetch_Count), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_req", 32'(if1.Imem_Req), 32'd0);
    check("t6_rst_valid", 32'(if1.Instr_Valid), 32'd0);
    check("t6_rst_pc", if1.Imem_Addr, 32'hFFFF_FFFC);
    check("t6_rst_count", 32'(if1.Fetch_Count), 32'd0);
    check("t6_dut0_rst_addr", if0.Imem_Addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
